// File: rtl/fpa_arb_pkg.sv
// Shared types and constants for the FPA request arbiter.
package fpa_arb_pkg;
    localparam int FP_W            = 8;
    localparam int EXC_W           = 4;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/fpa_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or after rr_ptr.
module rr_picker
    import fpa_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IW:0]          sum;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign req_dbl = {req, req} >> rr_ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = {1'b0, rr_ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(NUM_REQ)) begin
                    sum = sum - (IW+1)'(NUM_REQ);
                end
                grant_idx = sum[IW-1:0];
                any       = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = any && (grant_idx == IW'(gi));
        end
    endgenerate
endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter sharing one FPA among NUM_REQ requesters.
// Optional done watchdog enabled by defining FPA_ARB_TIMEOUT_EN.
module fpa_arbiter
    import fpa_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic                    rsp_valid,
    output logic [NUM_REQ-1:0]      rsp_id,
    output logic [FP_W-1:0]         rsp_ans,
    output logic [EXC_W-1:0]        rsp_except,
`ifdef FPA_ARB_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    busy,
    output logic                    fpa_start,
    output logic                    fpa_clr,
    output logic [FP_W-1:0]         fpa_a,
    output logic [FP_W-1:0]         fpa_b,
    input  logic                    fpa_done,
    input  logic [FP_W-1:0]         fpa_ans,
    input  logic [EXC_W-1:0]        fpa_except
);
    localparam int IW = $clog2(NUM_REQ);

    state_t             state_reg, state_next;
    logic [IW-1:0]      winner_reg, winner_next;
    logic [NUM_REQ-1:0] winner_oh_reg, winner_oh_next;
    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [FP_W-1:0]    fpa_a_reg, fpa_a_next;
    logic [FP_W-1:0]    fpa_b_reg, fpa_b_next;
    logic [FP_W-1:0]    rsp_ans_reg, rsp_ans_next;
    logic [EXC_W-1:0]   rsp_except_reg, rsp_except_next;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               any;

`ifdef FPA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          timeout_reg, timeout_next;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        state_next      = state_reg;
        winner_next     = winner_reg;
        winner_oh_next  = winner_oh_reg;
        rr_ptr_next     = rr_ptr_reg;
        fpa_a_next      = fpa_a_reg;
        fpa_b_next      = fpa_b_reg;
        rsp_ans_next    = rsp_ans_reg;
        rsp_except_next = rsp_except_reg;
`ifdef FPA_ARB_TIMEOUT_EN
        tmo_cnt_next    = tmo_cnt_reg;
        timeout_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (any) begin
                    state_next     = ISSUE;
                    winner_next    = grant_idx;
                    winner_oh_next = grant;
                    fpa_a_next     = req_a[grant_idx*FP_W +: FP_W];
                    fpa_b_next     = req_b[grant_idx*FP_W +: FP_W];
                end
            end
            ISSUE: begin
                state_next = WAIT;
`ifdef FPA_ARB_TIMEOUT_EN
                tmo_cnt_next = '0;
`endif
            end
            WAIT: begin
                if (fpa_done) begin
                    state_next      = RESP;
                    rsp_ans_next    = fpa_ans;
                    rsp_except_next = fpa_except;
                end
`ifdef FPA_ARB_TIMEOUT_EN
                else if (tmo_cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
                    // Give up: report all exception flags and reset the FPA.
                    state_next      = RESP;
                    rsp_ans_next    = '0;
                    rsp_except_next = '1;
                    timeout_next    = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + CW'(1);
                end
`endif
            end
            RESP: begin
                state_next  = IDLE;
                rr_ptr_next = (winner_reg == IW'(NUM_REQ - 1)) ? '0 : winner_reg + IW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            winner_reg     <= '0;
            winner_oh_reg  <= '0;
            rr_ptr_reg     <= '0;
            fpa_a_reg      <= '0;
            fpa_b_reg      <= '0;
            rsp_ans_reg    <= '0;
            rsp_except_reg <= '0;
`ifdef FPA_ARB_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            winner_reg     <= winner_next;
            winner_oh_reg  <= winner_oh_next;
            rr_ptr_reg     <= rr_ptr_next;
            fpa_a_reg      <= fpa_a_next;
            fpa_b_reg      <= fpa_b_next;
            rsp_ans_reg    <= rsp_ans_next;
            rsp_except_reg <= rsp_except_next;
`ifdef FPA_ARB_TIMEOUT_EN
            tmo_cnt_reg    <= tmo_cnt_next;
            timeout_reg    <= timeout_next;
`endif
        end
    end

    // Outputs are forced low during clr, even in the first cycle of reset.
    assign busy       = !clr && (state_reg != IDLE);
    assign fpa_start  = !clr && (state_reg == ISSUE);
    assign rsp_valid  = !clr && (state_reg == RESP);
    assign rsp_id     = rsp_valid ? winner_oh_reg : '0;
    assign rsp_ans    = clr ? '0 : rsp_ans_reg;
    assign rsp_except = clr ? '0 : rsp_except_reg;
    assign fpa_a      = clr ? '0 : fpa_a_reg;
    assign fpa_b      = clr ? '0 : fpa_b_reg;

`ifdef FPA_ARB_TIMEOUT_EN
    assign timeout_err = !clr && timeout_reg;
    assign fpa_clr     = clr || timeout_reg;
`else
    assign fpa_clr     = clr;
`endif
endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed self-checking bench for fpa_arbiter with a fixed-latency FPA model.
module tb_fpa_arbiter;
    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic [3:0]  rsp_id;
    logic [7:0]  rsp_ans;
    logic [3:0]  rsp_except;
`ifdef FPA_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif
    logic        busy;
    logic        fpa_start;
    logic        fpa_clr;
    logic [7:0]  fpa_a;
    logic [7:0]  fpa_b;
    logic        fpa_done = 1'b0;
    logic [7:0]  fpa_ans;
    logic [3:0]  fpa_except;

    logic [7:0]  model_ans;
    logic [3:0]  model_exc;
    bit          model_hang;
    int          model_cnt = 0;

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;
    int rsp_cnt   = 0;

    fpa_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ans    (rsp_ans),
        .rsp_except (rsp_except),
`ifdef FPA_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .busy       (busy),
        .fpa_start  (fpa_start),
        .fpa_clr    (fpa_clr),
        .fpa_a      (fpa_a),
        .fpa_b      (fpa_b),
        .fpa_done   (fpa_done),
        .fpa_ans    (fpa_ans),
        .fpa_except (fpa_except)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FPA model: done pulses 5 cycles after the edge that samples fpa_start.
    always @(posedge clk) begin
        if (fpa_clr) begin
            model_cnt <= 0;
            fpa_done  <= 1'b0;
        end else if (fpa_start && !model_hang) begin
            model_cnt <= 5;
            fpa_done  <= 1'b0;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            fpa_done  <= (model_cnt == 1);
        end else begin
            fpa_done <= 1'b0;
        end
    end
    assign fpa_ans    = model_ans;
    assign fpa_except = model_exc;

    always @(negedge clk) begin
        if (fpa_start === 1'b1) start_cnt++;
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (fpa_clr !== 1'b1) begin
            failures++; $display("FAIL reset_fpa_clr: got %b want 1", fpa_clr);
        end
        checks++;
        if ({fpa_start, rsp_valid, rsp_id, rsp_ans, rsp_except, fpa_a, fpa_b} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: start=%b valid=%b id=%b ans=%h exc=%b a=%h b=%h want all 0",
                     fpa_start, rsp_valid, rsp_id, rsp_ans, rsp_except, fpa_a, fpa_b);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (fpa_clr !== 1'b0) begin
            failures++; $display("FAIL release_fpa_clr: got %b want 0", fpa_clr);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL idle_busy: got %b want 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int n;
        bit ok;
        int s0;
        do_reset();
        model_ans = 8'h41;
        model_exc = 4'b0010;
        s0 = start_cnt;
        req_a = 32'h0000_003D;
        req_b = 32'h0000_0034;
        req   = 4'b0001;
        wait_rsp(50, n, ok);
        checks++;
        if (!ok || n != 8) begin
            failures++; $display("FAIL single_latency: got %0d (seen=%b) want 8", n, ok);
        end
        checks++;
        if (rsp_id !== 4'b0001) begin
            failures++; $display("FAIL single_id: got %b want 0001", rsp_id);
        end
        checks++;
        if (rsp_ans !== 8'h41 || rsp_except !== 4'b0010) begin
            failures++; $display("FAIL single_ans: got %h/%b want 41/0010", rsp_ans, rsp_except);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0);
        end
        req = 4'b0000;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_ans !== 8'h41) begin
            failures++;
            $display("FAIL single_hold: valid=%b busy=%b ans=%h want 0/0/41", rsp_valid, busy, rsp_ans);
        end
        $display("test_single latency=%0d id=%b ans=%h", n, rsp_id, rsp_ans);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ids [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_a   [0:4] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        int n;
        bit ok;
        int s0;
        do_reset();
        model_ans = 8'h52;
        s0 = start_cnt;
        req_a = 32'h4433_2211;
        req_b = 32'h8877_6655;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(50, n, ok);
            if (i == 4) req = 4'b0000;
            checks++;
            if (!ok || rsp_id !== exp_ids[i]) begin
                failures++; $display("FAIL rr_id[%0d]: got %b want %b", i, rsp_id, exp_ids[i]);
            end
            checks++;
            if (fpa_a !== exp_a[i]) begin
                failures++; $display("FAIL rr_operand[%0d]: got %h want %h", i, fpa_a, exp_a[i]);
            end
            $display("test_round_robin rsp %0d id=%b a=%h", i, rsp_id, fpa_a);
        end
        checks++;
        if (start_cnt - s0 != 5) begin
            failures++; $display("FAIL rr_starts: got %0d want 5", start_cnt - s0);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ids [0:2] = '{4'b0001, 4'b0100, 4'b0001};
        int n;
        bit ok;
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            wait_rsp(50, n, ok);
            if (i == 2) req = 4'b0000;
            checks++;
            if (!ok || rsp_id !== exp_ids[i]) begin
                failures++; $display("FAIL fair_id[%0d]: got %b want %b", i, rsp_id, exp_ids[i]);
            end
            $display("test_fairness rsp %0d id=%b", i, rsp_id);
        end
    endtask

    task automatic test_operand_isolation();
        int n;
        bit ok;
        do_reset();
        req_a = 32'h0000_003D;
        req_b = 32'h0000_0034;
        req   = 4'b0001;
        repeat (2) @(negedge clk);
        req_a = 32'h0000_00FF;
        req   = 4'b0000;
        @(negedge clk);
        checks++;
        if (fpa_a !== 8'h3D) begin
            failures++; $display("FAIL iso_wait_a: got %h want 3d", fpa_a);
        end
        wait_rsp(50, n, ok);
        checks++;
        if (!ok || rsp_id !== 4'b0001) begin
            failures++; $display("FAIL iso_rsp: seen=%b id=%b want 1/0001", ok, rsp_id);
        end
        checks++;
        if (fpa_a !== 8'h3D || fpa_b !== 8'h34) begin
            failures++; $display("FAIL iso_resp_ab: got %h/%h want 3d/34", fpa_a, fpa_b);
        end
        $display("test_operand_isolation a=%h b=%h", fpa_a, fpa_b);
    endtask

    task automatic test_midop_reset();
        int n;
        bit ok;
        int r0;
        do_reset();
        req_a = 32'h0102_0304;
        req   = 4'b0001;
        wait_rsp(50, n, ok);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        r0  = rsp_cnt;
        req = 4'b0000;
        clr = 1'b1;
        #1;
        checks++;
        if (fpa_clr !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_same_cycle: fpa_clr=%b busy=%b want 1/0", fpa_clr, busy);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL abort_idle: busy=%b want 0", busy);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rsp_cnt != r0) begin
            failures++; $display("FAIL abort_no_rsp: got %0d responses want 0", rsp_cnt - r0);
        end
        req = 4'b0011;
        wait_rsp(50, n, ok);
        req = 4'b0000;
        checks++;
        if (!ok || rsp_id !== 4'b0001) begin
            failures++; $display("FAIL abort_ptr_reset: seen=%b id=%b want 1/0001", ok, rsp_id);
        end
        $display("test_midop_reset next id=%b", rsp_id);
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        int r0;
        do_reset();
        model_hang = 1'b1;
        r0  = rsp_cnt;
        req = 4'b1000;
`ifdef FPA_ARB_TIMEOUT_EN
        wait_rsp(100, n, ok);
        req = 4'b0000;
        checks++;
        if (!ok || n != 34) begin
            failures++; $display("FAIL tmo_latency: got %0d (seen=%b) want 34", n, ok);
        end
        checks++;
        if (rsp_id !== 4'b1000 || rsp_ans !== 8'h00 || rsp_except !== 4'b1111) begin
            failures++;
            $display("FAIL tmo_rsp: id=%b ans=%h exc=%b want 1000/00/1111", rsp_id, rsp_ans, rsp_except);
        end
        checks++;
        if (timeout_err !== 1'b1 || fpa_clr !== 1'b1) begin
            failures++; $display("FAIL tmo_pulse: err=%b fpa_clr=%b want 1/1", timeout_err, fpa_clr);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || fpa_clr !== 1'b0) begin
            failures++; $display("FAIL tmo_pulse_end: err=%b fpa_clr=%b want 0/0", timeout_err, fpa_clr);
        end
        $display("test_timeout latency=%0d exc=%b", n, rsp_except);
`else
        n  = 0;
        ok = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL hang_busy: got %b want 1", busy);
        end
        checks++;
        if (rsp_cnt != r0) begin
            failures++; $display("FAIL hang_no_rsp: got %0d responses want 0", rsp_cnt - r0);
        end
        $display("test_timeout (disabled) busy=%b after 60 cycles", busy);
`endif
        model_hang = 1'b0;
        do_reset();
    endtask

    initial begin
        clr        = 1'b1;
        req        = 4'b0000;
        req_a      = 32'd0;
        req_b      = 32'd0;
        model_ans  = 8'h41;
        model_exc  = 4'b0010;
        model_hang = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_operand_isolation();
        test_midop_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
